// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states, word width.
// Imported by md_arith, md_ctrl and the bench so that every op encoding comes from one place.
package md_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result for mult/div from latched operands; zero latency, no handshake.
// wr is low for a divide by zero so the caller leaves HI/LO untouched.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              wr
);

    logic              sgn;
    logic              a_neg;
    logic              b_neg;
    logic [WORD_W-1:0] a_mag;
    logic [WORD_W-1:0] b_mag;
    logic [WORD_W-1:0] b_safe;
    logic [WORD_W-1:0] q_mag;
    logic [WORD_W-1:0] r_mag;
    logic [WORD_W-1:0] quot;
    logic [WORD_W-1:0] rem;
    logic [2*WORD_W-1:0] prod;

    assign sgn = (op == OP_MULT) || (op == OP_DIV);

    // Low 64 bits of a sign- or zero-extended 64x64 product equal the 32x32 result.
    assign prod = {{WORD_W{sgn & a[WORD_W-1]}}, a} * {{WORD_W{sgn & b[WORD_W-1]}}, b};

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    assign a_neg  = sgn & a[WORD_W-1];
    assign b_neg  = sgn & b[WORD_W-1];
    assign a_mag  = a_neg ? (~a + 1'b1) : a;
    assign b_mag  = b_neg ? (~b + 1'b1) : b;
    assign b_safe = (b_mag == '0) ? {{(WORD_W-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    assign rem    = a_neg ? (~r_mag + 1'b1) : r_mag;

    always_comb begin
        hi = prod[2*WORD_W-1:WORD_W];
        lo = prod[WORD_W-1:0];
        wr = 1'b1;
        if (is_div_op(op)) begin
            hi = rem;
            lo = quot;
            wr = (b != '0);
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide controller: mult/div busy for MULT_CYCLES/DIV_CYCLES, MTHI/MTLO in one edge.
// No handshake; stall asks the pipeline to hold an ID-stage md instruction while busy.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              md_use,
    output logic              busy,
    output logic              stall,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic [WORD_W-1:0] res_hi;
    logic [WORD_W-1:0] res_lo;
    logic              res_wr;

    md_arith u_arith (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .hi (res_hi),
        .lo (res_lo),
        .wr (res_wr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(op)) begin
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                        state_d = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                // Starts arriving here are dropped; the pipeline stalls them upstream.
                if (cnt_q <= CNT_ONE) begin
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy  = (state_q == ST_RUN);
    assign stall = md_use & (busy | (start & is_long_op(op)));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, cycles from start acceptance to HI/LO update for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, cycles from start acceptance to HI/LO update for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  EX-stage md instruction valid this cycle.
REQ-006 op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 a  input  32  rs operand, already forwarded.
REQ-008 b  input  32  rt operand, already forwarded.
REQ-009 md_use  input  1  ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 busy  output  1  operation in progress.
REQ-011 stall  output  1  request to freeze PC and IF/ID and bubble ID/EX.
REQ-012 hi  output  32  HI register.
REQ-013 lo  output  32  LO register.

Function
REQ-014 States IDLE and RUN; a down-counter holds the cycles remaining.
REQ-015 IDLE + start + op in {MULT,MULTU,DIV,DIVU}: latch op/a/b, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
REQ-016 busy is 1 in every RUN cycle, 0 in IDLE; busy rises the cycle after start.
REQ-017 RUN: decrement each cycle; on the cycle the counter reaches 1, write HI/LO at that edge and return to IDLE, so busy is high for exactly N cycles.
REQ-018 MULT: {hi,lo} = signed 64-bit a*b; MULTU: unsigned 64-bit product.
REQ-019 DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-021 Divide by zero (b = 0), DIV or DIVU: still runs DIV_CYCLES; hi and lo unchanged at completion.
REQ-022 IDLE + start + MTHI: hi <= a next edge; MTLO: lo <= a; no busy, no state change.
REQ-023 start while in RUN: ignored, no state change (pipeline guarantees this is not issued).
REQ-024 stall = md_use & (busy | (start & op is mult/div)), combinational.
REQ-025 hi/lo change only on completion (REQ-017) or MTHI/MTLO (REQ-022); reads always see the stable register value.
REQ-026 Latched operands isolate the result from a/b changing during RUN.

Reset
REQ-027 reset low: state IDLE, counter 0, busy 0, hi 0, lo 0, latched operands 0, immediately and independent of clk.
REQ-028 reset asserted mid-RUN: operation discarded, HI/LO read 0 after release.
REQ-029 First start is accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package md_pkg holds op encodings, state enumeration and the 32-bit word width constant.
REQ-031 One combinational sub-module md_arith computes the 64-bit product and the quotient/remainder pair from latched operands and op.
REQ-032 Counter width is sized from max(MULT_CYCLES, DIV_CYCLES).

Verification
REQ-033 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 DIVU a=100, b=7 -> busy high 10 cycles, then lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 MTHI a=0x12345678 then DIV b=0 -> hi=0x12345678 still after 10 busy cycles.
REQ-036 MULTU 0xFFFFFFFF*0xFFFFFFFF with md_use=1 on every following cycle -> stall high from the start cycle through the last busy cycle, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 Start MULT, assert reset in busy cycle 3 -> busy, hi, lo go to 0 at once; new MULT 6*7 after release -> lo=42.
REQ-038 Start asserted while busy with a different op -> ignored, original result written at the original completion cycle.
